// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin time-sharing of one 8x8 signed Booth multiplier among four requesters

// hybrid: combinational 8x8 signed radix-4 Booth multiplier
module hybrid (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    logic [8:0]  bx;
    logic [15:0] ae;
    logic [15:0] pp [4];
    assign bx = {b_i, 1'b0};
    assign ae = {{8{a_i[7]}}, a_i};
    for (genvar k = 0; k < 4; k++) begin : g_pp
        logic [2:0]  g;
        logic [15:0] m;
        assign g = bx[2*k +: 3];
        assign m = (g == 3'b001 || g == 3'b010) ? ae :
                   (g == 3'b011) ? ae << 1 :
                   (g == 3'b100) ? -(ae << 1) :
                   (g == 3'b101 || g == 3'b110) ? -ae : '0;
        assign pp[k] = m << (2*k);
    end
    assign p_o = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

module mul_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_prod,
    output logic [CNTW-1:0]      op_count,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
    state_t          state_q, state_d;
    logic [IDW-1:0]  last_gnt_q, last_gnt_d, op_id_q, op_id_d, rsp_id_q, rsp_id_d, win, idx;
    logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [15:0]     prod, rsp_prod_q, rsp_prod_d;
    logic [CNTW-1:0] op_count_q, op_count_d;
    logic            rsp_valid_q, rsp_valid_d, found, gnt_en;

    hybrid u_mul (.a_i(op_a_q), .b_i(op_b_q), .p_o(prod));

    // Round-robin search starting just after the last winner
    always_comb begin
        win   = last_gnt_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = last_gnt_q + IDW'(i);
            if (!found && req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign gnt_en    = state_q == IDLE || (state_q == RESP && rsp_ready);
    assign req_ready = (gnt_en && found) ? NREQ'(1) << win : '0;

    // Next state, operand capture on grant, and response bookkeeping
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        op_id_d     = op_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        op_count_d  = op_count_q;
        if (|req_ready) begin
            last_gnt_d = win;
            op_id_d    = win;
            op_a_d     = req_a[8*win +: 8];
            op_b_d     = req_b[8*win +: 8];
        end
        case (state_q)
            IDLE: state_d = found ? MUL : IDLE;
            MUL: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_prod_d  = prod;
                rsp_id_d    = op_id_q;
            end
            RESP: if (rsp_ready) begin
                op_count_d  = op_count_q + CNTW'(1);
                rsp_valid_d = 1'b0;
                state_d     = found ? MUL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= IDW'(NREQ - 1);
            op_id_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            op_id_q     <= op_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;
    assign op_count  = op_count_q;
    assign busy      = state_q != IDLE;
endmodule
